// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder: stereo sample FIFO and flow controller feeding an I2S DAC transmitter.
module audio_sample_feeder #(
  parameter int DATA_BITS     = 16,
  parameter int DEPTH_LOG2    = 4,
  parameter int PREFILL_LEVEL = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_BITS-1:0]  wr_data_L_i,
  input  logic [DATA_BITS-1:0]  wr_data_R_i,
  output logic [DATA_BITS-1:0]  i2s_sample_L_o,
  output logic [DATA_BITS-1:0]  i2s_sample_R_o,
  output logic                  i2s_send_o,
  input  logic                  i2s_done_i,
  input  logic                  i2s_lrck_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [7:0]            underrun_cnt_o
);
  localparam logic [DEPTH_LOG2:0] FULL    = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] PREFILL = (DEPTH_LOG2+1)'(PREFILL_LEVEL);
  typedef enum logic {FILL, STREAM} state_t;
  state_t state;
  logic [DATA_BITS-1:0] mem_l [2**DEPTH_LOG2];
  logic [DATA_BITS-1:0] mem_r [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] level_next;
  logic lrck_q, send_q, push, pop, frame_end, idle_end;
  assign wr_ready_o = level_o != FULL;
  assign push = wr_valid_i && wr_ready_o;
  // LRCK falling one cycle late tells us the transmitter hit its frame-end latch edge
  assign frame_end = lrck_q && !i2s_lrck_i;
  assign idle_end = frame_end && !send_q;
  assign pop = ((i2s_done_i && i2s_send_o) || (frame_end && send_q)) && level_o != '0;
  assign level_next = flush_i ? '0 : level_o + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  assign i2s_sample_L_o = level_o == '0 ? '0 : mem_l[rd_ptr];
  assign i2s_sample_R_o = level_o == '0 ? '0 : mem_r[rd_ptr];
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      mem_l[wr_ptr] <= wr_data_L_i;
      mem_r[wr_ptr] <= wr_data_R_i;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FILL;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_o        <= '0;
      i2s_send_o     <= 1'b0;
      underrun_cnt_o <= '0;
      lrck_q         <= 1'b0;
      send_q         <= 1'b0;
    end else begin
      lrck_q  <= i2s_lrck_i;
      send_q  <= i2s_send_o;
      level_o <= level_next;
      if (flush_i) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        state      <= FILL;
        i2s_send_o <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (state == FILL) begin
          i2s_send_o <= 1'b0;
          if (enable_i && level_o >= PREFILL) state <= STREAM;
        end else if (!enable_i || idle_end) begin
          state      <= FILL;
          i2s_send_o <= 1'b0;
          if (enable_i && idle_end && underrun_cnt_o != 8'hff) underrun_cnt_o <= underrun_cnt_o + 8'd1;
        end else begin
          i2s_send_o <= level_next != '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb_audio_sample_feeder: scoreboard bench with a behavioural I2S transmitter model (8-cycle frames).
module tb_audio_sample_feeder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic enable_i = 1'b0, flush_i = 1'b0, wr_valid_i = 1'b0;
  logic [15:0] wr_data_L_i = '0, wr_data_R_i = '0;
  logic wr_ready_o, i2s_send_o;
  logic [15:0] i2s_sample_L_o, i2s_sample_R_o;
  logic [4:0] level_o;
  logic [7:0] underrun_cnt_o;
  logic tx_done, tx_lrck, mon_lat;
  logic [2:0] tx_cnt;
  logic [15:0] seq = '0;
  logic [31:0] exp_q [$];
  logic [31:0] e;
  int checks = 0, failures = 0, n_latch = 0;
  always #5 clk = ~clk;
  audio_sample_feeder dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .flush_i(flush_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_data_L_i(wr_data_L_i), .wr_data_R_i(wr_data_R_i),
    .i2s_sample_L_o(i2s_sample_L_o), .i2s_sample_R_o(i2s_sample_R_o),
    .i2s_send_o(i2s_send_o), .i2s_done_i(tx_done), .i2s_lrck_i(tx_lrck),
    .level_o(level_o), .underrun_cnt_o(underrun_cnt_o)
  );
  // transmitter: latches on send when idle or at frame end; LRCK low for left half, high for right half
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b1;
      tx_lrck <= 1'b0;
      tx_cnt  <= '0;
    end else begin
      mon_lat = tx_done ? i2s_send_o : (tx_cnt == 3'd7 && i2s_send_o);
      if (tx_done) begin
        if (i2s_send_o) begin
          tx_done <= 1'b0;
          tx_cnt  <= '0;
        end
      end else if (tx_cnt == 3'd7) begin
        tx_lrck <= 1'b0;
        tx_cnt  <= '0;
        if (!i2s_send_o) tx_done <= 1'b1;
      end else begin
        tx_cnt  <= tx_cnt + 3'd1;
        tx_lrck <= tx_cnt >= 3'd3;
      end
      if (mon_lat) begin
        n_latch++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL latch_on_empty got=%h_%h exp=none", i2s_sample_L_o, i2s_sample_R_o);
        end else begin
          e = exp_q.pop_front();
          if ({i2s_sample_L_o, i2s_sample_R_o} !== e) begin
            failures++;
            $display("FAIL latch_data got=%h_%h exp=%h_%h", i2s_sample_L_o, i2s_sample_R_o, e[31:16], e[15:0]);
          end
        end
      end
    end
  end
  task automatic push_pair();
    wr_valid_i  = 1'b1;
    wr_data_L_i = 16'h1000 + seq;
    wr_data_R_i = 16'h2000 + seq;
    if (wr_ready_o && !flush_i) begin
      exp_q.push_back({wr_data_L_i, wr_data_R_i});
      seq++;
    end
    @(negedge clk);
    wr_valid_i = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 6;
    if (wr_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", wr_ready_o); end
    if (level_o !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_o); end
    if (i2s_send_o !== 1'b0) begin failures++; $display("FAIL reset_send got=%b exp=0", i2s_send_o); end
    if (i2s_sample_L_o !== 16'd0) begin failures++; $display("FAIL reset_L got=%h exp=0", i2s_sample_L_o); end
    if (i2s_sample_R_o !== 16'd0) begin failures++; $display("FAIL reset_R got=%h exp=0", i2s_sample_R_o); end
    if (underrun_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_underrun got=%0d exp=0", underrun_cnt_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_prefill();
    enable_i = 1'b1;
    repeat (7) push_pair();
    repeat (3) @(negedge clk);
    checks += 2;
    if (i2s_send_o !== 1'b0) begin failures++; $display("FAIL prefill7_send got=%b exp=0", i2s_send_o); end
    if (level_o !== 5'd7) begin failures++; $display("FAIL prefill7_level got=%0d exp=7", level_o); end
    push_pair();
    checks++;
    if (i2s_send_o !== 1'b0) begin failures++; $display("FAIL prefill8_send_c0 got=%b exp=0", i2s_send_o); end
    @(negedge clk);
    checks++;
    if (i2s_send_o !== 1'b0) begin failures++; $display("FAIL prefill8_send_c1 got=%b exp=0", i2s_send_o); end
    @(negedge clk);
    checks += 2;
    if (i2s_send_o !== 1'b1) begin failures++; $display("FAIL prefill8_send_c2 got=%b exp=1", i2s_send_o); end
    if (level_o !== 5'd8) begin failures++; $display("FAIL prefill8_level got=%0d exp=8", level_o); end
    @(negedge clk);
    checks += 3;
    if (level_o !== 5'd7) begin failures++; $display("FAIL start_pop_level got=%0d exp=7", level_o); end
    if (i2s_sample_L_o !== 16'h1001) begin failures++; $display("FAIL start_pop_head_L got=%h exp=1001", i2s_sample_L_o); end
    if (i2s_sample_R_o !== 16'h2001) begin failures++; $display("FAIL start_pop_head_R got=%h exp=2001", i2s_sample_R_o); end
  endtask
  task automatic test_stream();
    int n0;
    n0 = n_latch;
    for (int i = 0; i < 20; i++) begin
      push_pair();
      repeat (7) @(negedge clk);
    end
    checks += 2;
    if (n_latch - n0 < 19 || n_latch - n0 > 21) begin failures++; $display("FAIL stream_latches got=%0d exp=20", n_latch - n0); end
    if (underrun_cnt_o !== 8'd0) begin failures++; $display("FAIL stream_underrun got=%0d exp=0", underrun_cnt_o); end
  endtask
  task automatic test_underrun();
    for (int i = 0; i < 300 && !(tx_done && level_o == 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks += 5;
    if (tx_done !== 1'b1) begin failures++; $display("FAIL drain_tx_idle got=%b exp=1", tx_done); end
    if (underrun_cnt_o !== 8'd1) begin failures++; $display("FAIL drain_underrun got=%0d exp=1", underrun_cnt_o); end
    if (i2s_send_o !== 1'b0) begin failures++; $display("FAIL drain_send got=%b exp=0", i2s_send_o); end
    if (level_o !== 5'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", level_o); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain_unsent got=%0d exp=0", exp_q.size()); end
    repeat (7) push_pair();
    repeat (20) @(negedge clk);
    checks += 2;
    if (i2s_send_o !== 1'b0) begin failures++; $display("FAIL refill7_send got=%b exp=0", i2s_send_o); end
    if (tx_done !== 1'b1) begin failures++; $display("FAIL refill7_tx_idle got=%b exp=1", tx_done); end
    push_pair();
    repeat (3) @(negedge clk);
    checks += 2;
    if (tx_done !== 1'b0) begin failures++; $display("FAIL restart_tx_busy got=%b exp=0", tx_done); end
    if (level_o !== 5'd7) begin failures++; $display("FAIL restart_level got=%0d exp=7", level_o); end
  endtask
  task automatic test_full();
    for (int i = 0; i < 40 && wr_ready_o; i++) push_pair();
    checks += 2;
    if (wr_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", wr_ready_o); end
    if (level_o !== 5'd16) begin failures++; $display("FAIL full_level got=%0d exp=16", level_o); end
    wr_valid_i  = 1'b1;
    wr_data_L_i = 16'h1000 + seq;
    wr_data_R_i = 16'h2000 + seq;
    for (int i = 0; i < 40 && !wr_ready_o; i++) @(negedge clk);
    push_pair();
    checks++;
    if (level_o !== 5'd16) begin failures++; $display("FAIL held_push_level got=%0d exp=16", level_o); end
  endtask
  task automatic test_flush();
    logic prev;
    logic [7:0] uc;
    prev = tx_lrck;
    @(negedge clk);
    for (int i = 0; i < 40 && !(prev && !tx_lrck); i++) begin
      prev = tx_lrck;
      @(negedge clk);
    end
    uc = underrun_cnt_o;
    flush_i = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_L_i = 16'hdead;
    wr_data_R_i = 16'hbeef;
    exp_q.delete();
    @(negedge clk);
    flush_i = 1'b0;
    wr_valid_i = 1'b0;
    checks += 3;
    if (level_o !== 5'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level_o); end
    if (i2s_send_o !== 1'b0) begin failures++; $display("FAIL flush_send got=%b exp=0", i2s_send_o); end
    if (i2s_sample_L_o !== 16'd0) begin failures++; $display("FAIL flush_head got=%h exp=0", i2s_sample_L_o); end
    for (int i = 0; i < 40 && !tx_done; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks += 3;
    if (tx_done !== 1'b1) begin failures++; $display("FAIL flush_tx_idle got=%b exp=1", tx_done); end
    if (underrun_cnt_o !== uc) begin failures++; $display("FAIL flush_underrun got=%0d exp=%0d", underrun_cnt_o, uc); end
    if (level_o !== 5'd0) begin failures++; $display("FAIL flush_level_after got=%0d exp=0", level_o); end
  endtask
  task automatic test_disable();
    logic [7:0] uc;
    uc = underrun_cnt_o;
    repeat (10) push_pair();
    repeat (20) @(negedge clk);
    enable_i = 1'b0;
    for (int i = 0; i < 40 && !tx_done; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks += 5;
    if (tx_done !== 1'b1) begin failures++; $display("FAIL disable_tx_idle got=%b exp=1", tx_done); end
    if (underrun_cnt_o !== uc) begin failures++; $display("FAIL disable_underrun got=%0d exp=%0d", underrun_cnt_o, uc); end
    if (i2s_send_o !== 1'b0) begin failures++; $display("FAIL disable_send got=%b exp=0", i2s_send_o); end
    if (level_o !== 5'(exp_q.size())) begin failures++; $display("FAIL disable_level got=%0d exp=%0d", level_o, exp_q.size()); end
    e = exp_q.size() != 0 ? exp_q[0] : 32'd0;
    if ({i2s_sample_L_o, i2s_sample_R_o} !== e) begin failures++; $display("FAIL disable_head got=%h_%h exp=%h_%h", i2s_sample_L_o, i2s_sample_R_o, e[31:16], e[15:0]); end
  endtask
  initial begin
    test_reset();
    test_prefill();
    test_stream();
    test_underrun();
    test_full();
    test_flush();
    test_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
